// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory for the MEM stage with valid/ready requests
// and a fixed-latency response pulse. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module data_mem_ctrl #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 1024,
   parameter int LATENCY   = 1,
   parameter     INIT_FILE = ""
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           r_state, w_next;
   logic [2:0]       r_cnt;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_pend_rdata, r_resp_rdata;
   logic             r_pend_err, r_resp_err;

   logic             w_accept;
   logic [WIDTH-3:0] w_idx;
   logic             w_range_err, w_f3_err, w_mis_err, w_err;
   logic             w_half, w_word;
   logic [1:0]       w_lane;
   logic [3:0]       w_be;
   logic [WIDTH-1:0] w_wdata_rep, w_rd_word, w_shift, w_load;

   // Readiness depends only on state, so acceptance never loops through the FSM comb.
   assign w_accept = req_valid & (r_state != WAIT);

   assign w_idx       = req_addr[WIDTH-1:2];
   assign w_range_err = {2'b00, w_idx} >= 32'(DEPTH);
   assign w_f3_err    = req_we ? (req_funct3 > 3'd2)
                               : ((req_funct3 == 3'd3) | (req_funct3[2:1] == 2'b11));
   assign w_half      = (req_funct3[1:0] == 2'b01);
   assign w_word      = (req_funct3[1:0] == 2'b10);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_mis_err = (w_half & req_addr[0]) | (w_word & (|req_addr[1:0]));
   assign w_lane    = req_addr[1:0];
`else
   assign w_mis_err = 1'b0;
   assign w_lane    = w_word ? 2'b00 : (w_half ? {req_addr[1], 1'b0} : req_addr[1:0]);
`endif

   assign w_err = w_range_err | w_f3_err | w_mis_err;

   always_comb begin
      w_be        = 4'b1111;
      w_wdata_rep = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            w_be        = 4'b0001 << w_lane;
            w_wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_be        = 4'b0011 << w_lane;
            w_wdata_rep = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_rd_word = r_mem[w_idx[AW-1:0]];
   assign w_shift   = w_rd_word >> {w_lane, 3'b000};

   always_comb begin
      w_load = w_shift;
      case (req_funct3)
         3'b000:  w_load = {{24{w_shift[7]}},  w_shift[7:0]};
         3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_load = {24'd0, w_shift[7:0]};
         3'b101:  w_load = {16'd0, w_shift[15:0]};
         default: ;
      endcase
      if (w_err | req_we) w_load = '0;
   end

   // Storage is deliberately outside reset so committed stores survive a reset.
   always_ff @(posedge clk) begin
      if (w_accept & req_we & ~w_err) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx[AW-1:0]][8*i +: 8] <= w_wdata_rep[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      req_ready = 1'b1;
      case (r_state)
         IDLE: if (w_accept) w_next = (LATENCY > 1) ? WAIT : RESP;
         WAIT: begin
            req_ready = 1'b0;
            if (r_cnt == 3'(LATENCY - 1)) w_next = RESP;
         end
         RESP: w_next = w_accept ? ((LATENCY > 1) ? WAIT : RESP) : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               r_cnt <= 3'd0;
      else if (w_next != WAIT)  r_cnt <= 3'd0;
      else if (w_accept)        r_cnt <= 3'd1;
      else                      r_cnt <= r_cnt + 3'd1;
   end

   // Response registers only change when a new response starts, so they hold in between.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_rdata <= '0;
         r_pend_err   <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_pend_rdata <= w_load;
            r_pend_err   <= w_err;
         end
         if (w_accept && (LATENCY == 1)) begin
            r_resp_rdata <= w_load;
            r_resp_err   <= w_err;
         end else if ((r_state == WAIT) && (w_next == RESP)) begin
            r_resp_rdata <= r_pend_rdata;
            r_resp_err   <= r_pend_err;
         end
      end
   end

   assign resp_valid = (r_state == RESP);
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl: a byte-array reference model checks a LATENCY=1
// instance; a LATENCY=3 instance covers handshake timing and mid-operation reset.
module tb_data_mem_ctrl;

   localparam int DEPTH = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1_n, v1, we1, rdy1, rv1, er1;
   logic [2:0]  f1;
   logic [31:0] a1, wd1, rd1;
   logic        rst3_n, v3, we3, rdy3, rv3, er3;
   logic [2:0]  f3;
   logic [31:0] a3, wd3, rd3;

   data_mem_ctrl #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(1), .INIT_FILE("")) u_dut1 (
      .clk(clk), .rst_n(rst1_n), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
      .req_funct3(f1), .req_addr(a1), .req_wdata(wd1),
      .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1));

   data_mem_ctrl #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(3), .INIT_FILE("")) u_dut3 (
      .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
      .req_funct3(f3), .req_addr(a3), .req_wdata(wd3),
      .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference: flat byte array, little-endian, rules applied with plain arithmetic.
   logic [7:0] mb [4*DEPTH];

   task automatic model(input logic we, input logic [2:0] fn, input logic [31:0] addr,
                        input logic [31:0] wd, output logic err, output logic [31:0] rd);
      int unsigned n, a;
      n   = (fn[1:0] == 2'd0) ? 1 : ((fn[1:0] == 2'd1) ? 2 : 4);
      a   = addr;
      err = 1'b0;
      rd  = 32'd0;
      if (we ? (fn > 3'd2) : (fn == 3'd3 || fn > 3'd5)) err = 1'b1;
      if ((a >> 2) >= DEPTH) err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (a % n != 0) err = 1'b1;
`else
      a = a - (a % n);
`endif
      if (!err) begin
         if (we) begin
            for (int i = 0; i < int'(n); i++) mb[a + i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < int'(n); i++) rd = rd | (32'(mb[a + i]) << (8 * i));
            if (!fn[2] && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
         end
      end
   endtask

   logic        pend = 1'b0;
   logic        exp_err = 1'b0;
   logic [31:0] exp_rd = 32'd0;

   task automatic resp_chk();
      if (pend) begin
         chk("resp_valid", 32'(rv1), 32'd1);
         chk("resp_rdata", rd1, exp_rd);
         chk("resp_err", 32'(er1), 32'(exp_err));
      end else begin
         chk("resp_valid_idle", 32'(rv1), 32'd0);
         chk("resp_rdata_hold", rd1, exp_rd);
      end
   endtask

   // Called at a negedge: checks the previous response, then presents one request for a cycle.
   task automatic req1(input logic we, input logic [2:0] fn, input logic [31:0] addr,
                       input logic [31:0] wd);
      logic        e;
      logic [31:0] r;
      resp_chk();
      chk("req_ready", 32'(rdy1), 32'd1);
      model(we, fn, addr, wd, e, r);
      v1 = 1'b1; we1 = we; f1 = fn; a1 = addr; wd1 = wd;
      @(posedge clk);
      @(negedge clk);
      pend = 1'b1; exp_err = e; exp_rd = r;
   endtask

   task automatic idle1(input int n);
      for (int i = 0; i < n; i++) begin
         resp_chk();
         v1 = 1'b0;
         pend = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] ra;
      int          r;
      rst1_n = 1'b0; rst3_n = 1'b0;
      v1 = 1'b0; we1 = 1'b0; f1 = 3'd0; a1 = 32'd0; wd1 = 32'd0;
      v3 = 1'b0; we3 = 1'b0; f3 = 3'd0; a3 = 32'd0; wd3 = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(rdy1), 32'd1);
      chk("rst_valid", 32'(rv1), 32'd0);
      chk("rst_rdata", rd1, 32'd0);
      chk("rst_err", 32'(er1), 32'd0);
      rst1_n = 1'b1; rst3_n = 1'b1;
      @(negedge clk);

      for (int w = 0; w < 64; w++) req1(1'b1, 3'd2, 32'(w * 4), $urandom);

      // Byte-lane store then word load, back to back.
      req1(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      req1(1'b1, 3'd0, 32'h11, 32'h0000005A);
      req1(1'b0, 3'd2, 32'h10, 32'd0);
      chk("tp_lane_lw", rd1, 32'hDEAD5AEF);

      req1(1'b1, 3'd2, 32'h20, 32'h80F07F81);
      req1(1'b0, 3'd0, 32'h20, 32'd0);
      chk("tp_lb", rd1, 32'hFFFFFF81);
      req1(1'b0, 3'd4, 32'h20, 32'd0);
      chk("tp_lbu", rd1, 32'h00000081);
      req1(1'b0, 3'd1, 32'h22, 32'd0);
      chk("tp_lh", rd1, 32'hFFFF80F0);
      req1(1'b0, 3'd5, 32'h22, 32'd0);
      chk("tp_lhu", rd1, 32'h000080F0);

      req1(1'b1, 3'd2, 32'h30, 32'hA5A5A5A5);
      req1(1'b1, 3'd2, 32'h31, 32'h11223344);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("tp_mis_err", 32'(er1), 32'd1);
      req1(1'b0, 3'd2, 32'h30, 32'd0);
      chk("tp_mis_word", rd1, 32'hA5A5A5A5);
`else
      chk("tp_mis_err", 32'(er1), 32'd0);
      req1(1'b0, 3'd2, 32'h30, 32'd0);
      chk("tp_mis_word", rd1, 32'h11223344);
`endif

      req1(1'b0, 3'd2, 32'(4 * DEPTH), 32'd0);
      chk("tp_range_err", 32'(er1), 32'd1);
      chk("tp_range_rdata", rd1, 32'd0);
      req1(1'b0, 3'd3, 32'h10, 32'd0);
      chk("tp_f3_err", 32'(er1), 32'd1);
      idle1(2);

      for (int k = 0; k < 300; k++) begin
         r = int'($urandom_range(0, 19));
         if (r == 0)      ra = 32'(4 * DEPTH) + $urandom_range(0, 255);
         else if (r == 1) ra = $urandom;
         else             ra = $urandom_range(0, 255);
         req1(1'(($urandom_range(0, 1))), 3'($urandom_range(0, 7)), ra, $urandom);
         if ($urandom_range(0, 4) == 0) idle1(int'($urandom_range(1, 2)));
      end
      idle1(2);

      // LATENCY=3: accepted in "cycle 5", ready low 6-7, response in 8 only.
      v3 = 1'b1; we3 = 1'b1; f3 = 3'd2; a3 = 32'h40; wd3 = 32'hCAFEF00D;
      @(posedge clk); @(negedge clk);
      chk("l3_c6_ready", 32'(rdy3), 32'd0);
      chk("l3_c6_valid", 32'(rv3), 32'd0);
      we3 = 1'b0; f3 = 3'd2; a3 = 32'h40;
      @(posedge clk); @(negedge clk);
      chk("l3_c7_ready", 32'(rdy3), 32'd0);
      chk("l3_c7_valid", 32'(rv3), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("l3_c8_valid", 32'(rv3), 32'd1);
      chk("l3_c8_ready", 32'(rdy3), 32'd1);
      chk("l3_c8_err", 32'(er3), 32'd0);
      chk("l3_c8_rdata", rd3, 32'd0);
      @(posedge clk); @(negedge clk);
      v3 = 1'b0;
      chk("l3_c9_valid", 32'(rv3), 32'd0);
      chk("l3_c9_ready", 32'(rdy3), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("l3_c10_valid", 32'(rv3), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("l3_c11_valid", 32'(rv3), 32'd1);
      chk("l3_c11_rdata", rd3, 32'hCAFEF00D);
      @(posedge clk); @(negedge clk);
      chk("l3_c12_valid", 32'(rv3), 32'd0);
      chk("l3_c12_hold", rd3, 32'hCAFEF00D);

      // Reset during WAIT drops the response but keeps the committed store.
      v3 = 1'b1; we3 = 1'b1; f3 = 3'd2; a3 = 32'h44; wd3 = 32'h0BADC0DE;
      @(posedge clk); @(negedge clk);
      v3 = 1'b0;
      #2 rst3_n = 1'b0;
      #1;
      chk("rst3_valid", 32'(rv3), 32'd0);
      chk("rst3_rdata", rd3, 32'd0);
      chk("rst3_err", 32'(er3), 32'd0);
      chk("rst3_ready", 32'(rdy3), 32'd1);
      repeat (2) @(negedge clk);
      rst3_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst3_no_pulse", 32'(rv3), 32'd0);
         chk("rst3_ready_after", 32'(rdy3), 32'd1);
      end
      v3 = 1'b1; we3 = 1'b0; f3 = 3'd2; a3 = 32'h44;
      @(posedge clk); @(negedge clk);
      v3 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst3_store_kept_v", 32'(rv3), 32'd1);
      chk("rst3_store_kept", rd3, 32'h0BADC0DE);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
